// File: rtl/ps2_key_event_queue.sv
// PS/2 scan-code parser feeding a key-state map, held-key counter and a
// make/break event FIFO with a valid/ready pop handshake.
//
//   state  | meaning
//   INIT   | waiting for the 0xAA self-test byte, all other bytes ignored
//   IDLE   | between codes, no prefix pending
//   GOT_E0 | extended prefix seen
//   GOT_F0 | break prefix seen, next byte completes a release
module ps2_key_event_queue #(
  parameter int FIFO_DEPTH    = 8,
  parameter int FILTER_REPEAT = 1,
  parameter int DROP_W        = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  byte_in,
  input  logic                        byte_valid,
  input  logic                        byte_err,
  input  logic                        evt_ready,
  output logic                        ready,
  output logic [511:0]                key_down,
  output logic [9:0]                  held_count,
  output logic                        evt_valid,
  output logic [9:0]                  evt_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [DROP_W-1:0]           drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {INIT, IDLE, GOT_E0, GOT_F0} state_e;

  state_e            state_q, state_d;
  logic              ext_q, ext_d;
  logic              ready_q, ready_d;
  logic [511:0]      key_q, key_d;
  logic [9:0]        held_q, held_d;
  logic [9:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic       done, done_brk, done_ext, hot_clr;
  logic [8:0] idx;
  logic       key_bit, push, pop, full, accept;

  always_comb begin
    state_d  = state_q;
    ext_d    = ext_q;
    ready_d  = ready_q;
    done     = 1'b0;
    done_brk = 1'b0;
    done_ext = 1'b0;
    hot_clr  = 1'b0;
    // An error abandons any partial code; it never releases INIT.
    if (byte_err) begin
      if (state_q != INIT) begin
        state_d = IDLE;
        ext_d   = 1'b0;
      end
    end else if (byte_valid) begin
      case (state_q)
        INIT: begin
          if (byte_in == 8'hAA) begin
            state_d = IDLE;
            ready_d = 1'b1;
          end
        end
        IDLE: begin
          if (byte_in == 8'hE0) begin
            state_d = GOT_E0;
            ext_d   = 1'b1;
          end else if (byte_in == 8'hF0) begin
            state_d = GOT_F0;
            ext_d   = 1'b0;
          end else if (byte_in == 8'hAA) begin
            hot_clr = 1'b1;
          end else begin
            done = 1'b1;
          end
        end
        GOT_E0: begin
          if (byte_in == 8'hF0) begin
            state_d = GOT_F0;
          end else if (byte_in != 8'hE0) begin
            done     = 1'b1;
            done_ext = 1'b1;
            state_d  = IDLE;
            ext_d    = 1'b0;
          end
        end
        GOT_F0: begin
          done     = 1'b1;
          done_brk = 1'b1;
          done_ext = ext_q;
          state_d  = IDLE;
          ext_d    = 1'b0;
        end
        default: state_d = INIT;
      endcase
    end
  end

  assign idx     = {done_ext, byte_in};
  assign key_bit = key_q[idx];
  assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop     = (cnt_q != '0) && evt_ready;

  always_comb begin
    key_d  = key_q;
    held_d = held_q;
    push   = 1'b0;
    if (hot_clr) begin
      key_d  = '0;
      held_d = '0;
    end else if (done) begin
      // Orphan breaks and filtered repeats leave everything untouched.
      if (done_brk) begin
        if (key_bit) begin
          key_d[idx] = 1'b0;
          held_d     = held_q - 10'd1;
          push       = 1'b1;
        end
      end else if (!key_bit) begin
        key_d[idx] = 1'b1;
        held_d     = held_q + 10'd1;
        push       = 1'b1;
      end else if (FILTER_REPEAT == 0) begin
        push = 1'b1;
      end
    end
  end

  assign accept = push && (!full || pop);

  always_comb begin
    rd_d   = pop ? rd_q + 1'b1 : rd_q;
    wr_d   = accept ? wr_q + 1'b1 : wr_q;
    cnt_d  = cnt_q + (AW+1)'(accept) - (AW+1)'(pop);
    drop_d = drop_q;
    if (push && full && !pop && (drop_q != '1)) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      ext_q   <= 1'b0;
      ready_q <= 1'b0;
      key_q   <= '0;
      held_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      ext_q   <= ext_d;
      ready_q <= ready_d;
      key_q   <= key_d;
      held_q  <= held_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_q] <= {done_brk, done_ext, byte_in};
  end

  assign ready      = ready_q;
  assign key_down   = key_q;
  assign held_count = held_q;
  assign evt_valid  = (cnt_q != '0);
  assign evt_data   = evt_valid ? mem_q[rd_q] : 10'd0;
  assign fifo_count = cnt_q;
  assign drop_count = drop_q;
endmodule
